// File: rtl/ram_bus_master.sv
// Initiator for the asynchronous RAM bus: turns one-cycle CPU requests into SETUP/ACCESS/HOLD cycles.
// Optional write read-back verify is enabled with `define RAM_MASTER_VERIFY_EN.
module ram_bus_master #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 4,
    parameter int ACCESS_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_resp,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              verify_err,
    output logic [ADDR_W-1:0] address_RAM,
    output logic              csRAM,
    output logic              weRAM,
    inout  wire  [DATA_W-1:0] data_RAM
);
    localparam int CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, ACCESS, HOLD, VSETUP, VACCESS, VHOLD
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              op_we_reg;
    logic [DATA_W-1:0] op_wdata_reg;
    logic              drive_reg;

    // The bus is only ever driven while a write is in flight (SETUP through HOLD).
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bus
        assign data_RAM[gi] = drive_reg ? op_wdata_reg[gi] : 1'bz;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            op_we_reg    <= 1'b0;
            op_wdata_reg <= '0;
            drive_reg    <= 1'b0;
            address_RAM  <= '0;
            csRAM        <= 1'b0;
            weRAM        <= 1'b0;
            cpu_ready    <= 1'b1;
            cpu_resp     <= 1'b0;
            cpu_rdata    <= '0;
`ifdef RAM_MASTER_VERIFY_EN
            verify_err   <= 1'b0;
`endif
        end else begin
            cpu_resp <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cpu_req) begin
                        op_we_reg    <= cpu_we;
                        op_wdata_reg <= cpu_wdata;
                        address_RAM  <= cpu_addr;
                        drive_reg    <= cpu_we;
                        cpu_ready    <= 1'b0;
                        state_reg    <= SETUP;
                    end
                end
                SETUP: begin
                    csRAM     <= 1'b1;
                    weRAM     <= op_we_reg;
                    cnt_reg   <= CNT_INIT;
                    state_reg <= ACCESS;
                end
                ACCESS: begin
                    if (cnt_reg == '0) begin
                        csRAM <= 1'b0;
                        weRAM <= 1'b0;
                        if (!op_we_reg)
                            cpu_rdata <= data_RAM;
`ifdef RAM_MASTER_VERIFY_EN
                        // Writes report completion only after the read-back.
                        cpu_resp   <= !op_we_reg;
                        verify_err <= 1'b0;
`else
                        cpu_resp <= 1'b1;
`endif
                        state_reg <= HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                HOLD: begin
                    drive_reg <= 1'b0;
`ifdef RAM_MASTER_VERIFY_EN
                    if (op_we_reg) begin
                        state_reg <= VSETUP;
                    end else begin
                        cpu_ready <= 1'b1;
                        state_reg <= IDLE;
                    end
`else
                    cpu_ready <= 1'b1;
                    state_reg <= IDLE;
`endif
                end
`ifdef RAM_MASTER_VERIFY_EN
                VSETUP: begin
                    csRAM     <= 1'b1;
                    weRAM     <= 1'b0;
                    cnt_reg   <= CNT_INIT;
                    state_reg <= VACCESS;
                end
                VACCESS: begin
                    if (cnt_reg == '0) begin
                        csRAM      <= 1'b0;
                        cpu_rdata  <= data_RAM;
                        verify_err <= (data_RAM != op_wdata_reg);
                        cpu_resp   <= 1'b1;
                        state_reg  <= VHOLD;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                VHOLD: begin
                    cpu_ready <= 1'b1;
                    state_reg <= IDLE;
                end
`endif
                default: begin
                    csRAM     <= 1'b0;
                    weRAM     <= 1'b0;
                    drive_reg <= 1'b0;
                    cpu_ready <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifndef RAM_MASTER_VERIFY_EN
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Randomized bench for ram_bus_master with a behavioural RAM device and a phase-level reference model.
// Define RAM_MASTER_VERIFY_EN to exercise the write read-back build.
module tb_ram_bus_master;
    localparam int AW = 12;
    localparam int DW = 4;
    localparam int AC = 2;
`ifdef RAM_MASTER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic          cpu_resp;
    logic [DW-1:0] cpu_rdata;
    logic          verify_err;
    logic [AW-1:0] address_RAM;
    logic          csRAM;
    logic          weRAM;
    wire  [DW-1:0] data_RAM;

    ram_bus_master #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYC(AC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata),
        .verify_err(verify_err),
        .address_RAM(address_RAM), .csRAM(csRAM), .weRAM(weRAM), .data_RAM(data_RAM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM device: drives the bus while selected for read, stores on selected-write edges.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic          stuck;
    assign data_RAM = (csRAM && !weRAM) ? ram_mem[address_RAM] : 4'bz;
    always @(posedge clk)
        if (csRAM && weRAM)
            ram_mem[address_RAM] <= stuck ? (data_RAM & 4'hE) : data_RAM;

    // Reference state
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    logic [DW-1:0] last_rdata;
    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // weRAM must not change while chip select is held
    logic cs_prev, we_prev;
    always @(negedge clk) begin
        if (rst_n && cs_prev && csRAM)
            check("we_stable", weRAM, we_prev);
        cs_prev <= csRAM;
        we_prev <= weRAM;
    end

    // One transaction from IDLE; returns at the first IDLE negedge afterwards.
    task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int last;
        int pos;
        bit seg1;
        logic [DW-1:0] stored;
        logic [DW-1:0] exp_rd;
        logic exp_err;
        last    = (w && VER) ? 2*AC+4 : AC+2;
        stored  = stuck ? (d & 4'hE) : d;
        exp_err = 1'b0;
        exp_rd  = last_rdata;
        if (!w) begin
            exp_rd = exp_mem[a];
        end else begin
            exp_mem[a] = stored;
            if (VER) begin
                exp_rd  = stored;
                exp_err = (stored != d);
            end
        end
        check("ready_idle", cpu_ready, 1);
        cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = d;
        for (int n = 1; n <= last + 1; n++) begin
            @(negedge clk);
            // Scramble the request inputs while busy: they must be ignored.
            cpu_req   = (n < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = AW'($urandom);
            cpu_wdata = DW'($urandom);
            if (n > last) begin
                check("ready_after", cpu_ready, 1);
                check("resp_after", cpu_resp, 0);
                check("cs_after", csRAM, 0);
            end else begin
                seg1 = (n <= AC + 2);
                pos  = seg1 ? n - 1 : n - AC - 3;
                check("ready_busy", cpu_ready, 0);
                check("cs", csRAM, (pos >= 1 && pos <= AC));
                check("we", weRAM, (pos >= 1 && pos <= AC && w && seg1));
                check("addr", address_RAM, a);
                check("resp", cpu_resp, (n == last));
                if (w && seg1)
                    check("wbus", data_RAM, d);
                if (n == last) begin
                    check("rdata", cpu_rdata, exp_rd);
                    check("verify_err", verify_err, exp_err);
                end
            end
        end
        last_rdata = exp_rd;
        $display("txn %s addr=0x%03h wdata=0x%0h rdata=0x%0h verr=%0d", w ? "WR" : "RD", a, d,
                 cpu_rdata, verify_err);
    endtask

    task automatic reset_mid_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("rst_pre_cs", csRAM, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_cs", csRAM, 0);
        check("rst_we", weRAM, 0);
        check("rst_ready", cpu_ready, 1);
        check("rst_resp", cpu_resp, 0);
        check("rst_addr", address_RAM, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_resp", cpu_resp, 0);
            check("rst_idle_cs", csRAM, 0);
        end
        $display("txn RESET during write addr=0x%03h dropped", a);
    endtask

    logic [AW-1:0] pool [8];

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; stuck = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        last_rdata = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", cpu_ready, 1);
        check("reset_cs", csRAM, 0);
        check("reset_we", weRAM, 0);
        check("reset_addr", address_RAM, 0);
        check("reset_resp", cpu_resp, 0);
        check("reset_rdata", cpu_rdata, 0);
        check("reset_verr", verify_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b1, 12'h123, 4'hA);
        txn(1'b0, 12'h123, 4'h0);
        check("dir_rd_123", cpu_rdata, 4'hA);
        txn(1'b1, 12'h000, 4'h5);
        txn(1'b1, 12'hFFF, 4'hF);
        txn(1'b0, 12'h000, 4'h0);
        check("dir_rd_000", cpu_rdata, 4'h5);
        txn(1'b0, 12'hFFF, 4'h0);
        check("dir_rd_fff", cpu_rdata, 4'hF);

        txn(1'b1, 12'h200, 4'h6);
        reset_mid_write(12'h200, 4'h9);
        txn(1'b0, 12'h200, 4'h0);
        check("rst_mem_kept", cpu_rdata, 4'h6);

        pool[0] = 12'h000; pool[1] = 12'hFFF; pool[2] = 12'h123; pool[3] = 12'h200;
        for (int i = 4; i < 8; i++) begin
            pool[i] = AW'($urandom);
            txn(1'b1, pool[i], DW'($urandom));
        end
        for (int i = 0; i < 40; i++)
            txn(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], DW'($urandom));

        if (VER) begin
            stuck = 1'b1;
            txn(1'b1, 12'h010, 4'h3);
            check("stuck_rdata", cpu_rdata, 4'h2);
            stuck = 1'b0;
            txn(1'b1, 12'h010, 4'h3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end
endmodule
